// File: rtl/pwm_ctrl_pkg.sv
// Shared encodings and constants for the duty-button front-end and PWM stage.
// Auto-repeat is enabled by defining DUTY_BTN_AUTOREPEAT_EN.
package pwm_ctrl_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_HOLD   = HOLD,
        ST_REPEAT = REPEAT
    } btn_state_e;

    localparam int COARSE_STEP = 10;
    localparam int FINE_STEP   = 1;
    localparam int DUTY_MIN    = 0;
    localparam int DUTY_MAX    = 1000;

    // Counter width able to hold n without wrapping.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/duty_button_ctrl_channel.sv
// One button: two-FF synchroniser, tick-sampled debounce and press FSM.
// Auto-repeat (HOLD/REPEAT) is compiled only with DUTY_BTN_AUTOREPEAT_EN.
module btn_channel
    import pwm_ctrl_pkg::*;
#(
    parameter int DB_TICKS   = 3,
    parameter int HOLD_TICKS = 4,
    parameter int REP_TICKS  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic held,
    output logic pulse,
    output logic coarse
);

    localparam int DBW = cnt_w(DB_TICKS);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICKS - 1);

    logic           sync1_q, sync2_q;
    logic           stable_q, stable_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    btn_state_e     state_q, state_d;
    logic           rise, fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (tick) begin
            if (sync2_q == stable_q) begin
                db_cnt_d = '0;
            end else if (db_cnt_q == DB_LAST) begin
                stable_d = ~stable_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    assign rise = stable_d & ~stable_q;
    assign fall = ~stable_d & stable_q;
    // Next-cycle level, so the top registers it alongside the pulse.
    assign held = stable_d;

`ifdef DUTY_BTN_AUTOREPEAT_EN
    localparam int RMAX = (HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS;
    localparam int RW = cnt_w(RMAX);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_TICKS - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REP_TICKS - 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        pulse     = 1'b0;
        coarse    = 1'b0;
        // Release is checked first so it beats a repeat completing on the same tick.
        if (fall) begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
        end else if (rise) begin
            state_d   = ST_HOLD;
            rep_cnt_d = '0;
            pulse     = 1'b1;
            coarse    = 1'b1;
        end else if (tick) begin
            unique case (state_q)
                ST_HOLD: begin
                    if (rep_cnt_q == HOLD_LAST) begin
                        pulse     = 1'b1;
                        state_d   = ST_REPEAT;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (rep_cnt_q == REP_LAST) begin
                        pulse     = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    localparam int unused_ticks = HOLD_TICKS + REP_TICKS;

    // ST_HOLD serves as the single PRESSED state.
    always_comb begin
        state_d = state_q;
        pulse   = 1'b0;
        coarse  = 1'b0;
        if (fall) begin
            state_d = ST_IDLE;
        end else if (rise && state_q == ST_IDLE) begin
            state_d = ST_HOLD;
            pulse   = 1'b1;
            coarse  = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/duty_button_ctrl.sv
// Button front-end: shared tick, two debounced channels, conflict mask, output regs.
// Auto-repeat fine steps are enabled by defining DUTY_BTN_AUTOREPEAT_EN.
module duty_button_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int TICK_DIV   = 2,
    parameter int DB_TICKS   = 3,
    parameter int HOLD_TICKS = 4,
    parameter int REP_TICKS  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic increase_duty,
    input  logic decrease_duty,
    output logic inc_pulse,
    output logic dec_pulse,
    output logic step_coarse,
    output logic inc_held,
    output logic dec_held
);

    localparam int TW = cnt_w(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic          inc_held_c, dec_held_c;
    logic          inc_p, dec_p, inc_c, dec_c;
    logic          conflict;
    logic          inc_pulse_q, inc_pulse_d;
    logic          dec_pulse_q, dec_pulse_d;
    logic          coarse_q, coarse_d;
    logic          inc_held_q, dec_held_q;

    assign tick       = (tick_cnt_q == TICK_LAST);
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    btn_channel #(
        .DB_TICKS  (DB_TICKS),
        .HOLD_TICKS(HOLD_TICKS),
        .REP_TICKS (REP_TICKS)
    ) u_inc (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (increase_duty),
        .held  (inc_held_c),
        .pulse (inc_p),
        .coarse(inc_c)
    );

    btn_channel #(
        .DB_TICKS  (DB_TICKS),
        .HOLD_TICKS(HOLD_TICKS),
        .REP_TICKS (REP_TICKS)
    ) u_dec (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .raw   (decrease_duty),
        .held  (dec_held_c),
        .pulse (dec_p),
        .coarse(dec_c)
    );

    // Mask on the levels that will be visible together with the pulse.
    assign conflict = inc_held_c & dec_held_c;

    always_comb begin
        inc_pulse_d = inc_p & ~conflict;
        dec_pulse_d = dec_p & ~conflict & ~inc_p;
        coarse_d    = (inc_pulse_d & inc_c) | (dec_pulse_d & dec_c);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt_q  <= '0;
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
            coarse_q    <= 1'b0;
            inc_held_q  <= 1'b0;
            dec_held_q  <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            inc_pulse_q <= inc_pulse_d;
            dec_pulse_q <= dec_pulse_d;
            coarse_q    <= coarse_d;
            inc_held_q  <= inc_held_c;
            dec_held_q  <= dec_held_c;
        end
    end

    assign inc_pulse   = inc_pulse_q;
    assign dec_pulse   = dec_pulse_q;
    assign step_coarse = coarse_q;
    assign inc_held    = inc_held_q;
    assign dec_held    = dec_held_q;

endmodule
